// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte requesters,
// with per-requester packet locking and a start-acknowledge timeout.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       uart_tx_start,
  output logic [7:0]                 uart_tx_data,
  input  logic                       uart_tx_done,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       locked,
  output logic                       err_timeout
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_LOW, WAIT_HIGH} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic              last_q, last_next;
  logic [GW-1:0]     grant_next;
  logic [7:0]        data_next;
  logic [N_REQ-1:0]  ready_next;
  logic              start_next, locked_next, err_next;
  logic              found;
  logic [GW-1:0]     cand;

  // Rotating-priority search; scanning from the farthest offset down leaves the
  // nearest valid requester after the current holder as the winner.
  always_comb begin
    found = 1'b0;
    cand  = grant_id;
    if (locked) begin
      found = req_valid[grant_id];
    end else begin
      for (int k = N_REQ; k >= 1; k--) begin
        if (req_valid[(int'(grant_id) + k) % N_REQ]) begin
          found = 1'b1;
          cand  = GW'((int'(grant_id) + k) % N_REQ);
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    last_next   = last_q;
    grant_next  = grant_id;
    data_next   = uart_tx_data;
    locked_next = locked;
    start_next  = 1'b0;
    ready_next  = '0;
    err_next    = 1'b0;
    case (state)
      IDLE: begin
        if (uart_tx_done && found) begin
          state_next        = START;
          grant_next        = cand;
          data_next         = req_data[8*cand +: 8];
          last_next         = req_last[cand];
          start_next        = 1'b1;
          ready_next[cand]  = 1'b1;
        end
      end
      START: begin
        state_next = WAIT_LOW;
        cnt_next   = '0;
      end
      WAIT_LOW: begin
        if (!uart_tx_done) begin
          state_next = WAIT_HIGH;
        end else if (cnt == CW'(DONE_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte and any lock.
          err_next    = 1'b1;
          locked_next = 1'b0;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (uart_tx_done) begin
          state_next  = IDLE;
          locked_next = ~last_q;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_q        <= 1'b0;
      grant_id      <= GW'(N_REQ - 1);
      uart_tx_data  <= 8'h00;
      uart_tx_start <= 1'b0;
      req_ready     <= '0;
      locked        <= 1'b0;
      err_timeout   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      last_q        <= last_next;
      grant_id      <= grant_next;
      uart_tx_data  <= data_next;
      uart_tx_start <= start_next;
      req_ready     <= ready_next;
      locked        <= locked_next;
      err_timeout   <= err_next;
      busy          <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model that
// records every byte it accepts onto a line queue.
module tb_uart_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int DONE_TIMEOUT = 16;
  localparam int FRAME        = 10;
  localparam int BUDGET       = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_done;
  logic [1:0]  grant_id;
  logic        busy, locked, err_timeout;

  logic        tie_high = 1'b0;
  int          tx_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  int          start_count = 0;
  int          sc;
  logic [7:0]  line_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
    .uart_tx_done(uart_tx_done), .grant_id(grant_id), .busy(busy),
    .locked(locked), .err_timeout(err_timeout)
  );

  // Transmitter stand-in: done falls two cycles after start, frame lasts FRAME cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_tx_done <= 1'b1;
      tx_cnt       <= 0;
    end else if (tx_cnt == 0) begin
      if (uart_tx_start && !tie_high) begin
        tx_cnt <= 1;
        line_q.push_back(uart_tx_data);
      end
    end else if (tx_cnt == 1) begin
      uart_tx_done <= 1'b0;
      tx_cnt       <= 2;
    end else if (tx_cnt == FRAME) begin
      uart_tx_done <= 1'b1;
      tx_cnt       <= 0;
    end else begin
      tx_cnt <= tx_cnt + 1;
    end
  end

  always @(posedge clk) if (uart_tx_start) start_count++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic v, input logic [7:0] d, input logic l);
    req_valid[id]        = v;
    req_data[8*id +: 8]  = d;
    req_last[id]         = l;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for the start pulse, checks the grant, then checks the pulse is single-cycle.
  task automatic serveByte(input string tag, input int id, input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    while (!uart_tx_start && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_start"}, uart_tx_start, 1);
    checkOutput({tag, "_grant"}, grant_id, id);
    checkOutput({tag, "_data"}, uart_tx_data, d);
    checkOutput({tag, "_ready"}, req_ready, 32'(1) << id);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, {req_ready, uart_tx_start}, 0);
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    while (busy && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  task automatic checkLine(input string tag, input logic [7:0] exp);
    logic [8:0] got;
    if (line_q.size() == 0) got = 9'h100;
    else got = {1'b0, line_q.pop_front()};
    checkOutput({tag, "_line"}, got, {1'b0, exp});
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_start", uart_tx_start, 0);
    checkOutput("rst_data", uart_tx_data, 0);
    checkOutput("rst_grant", grant_id, 3);
    checkOutput("rst_flags", {busy, locked, err_timeout}, 0);
    rst = 1'b0;

    // Single byte
    applyStimulus(0, 1'b1, 8'h55, 1'b1);
    serveByte("single", 0, 8'h55);
    applyStimulus(0, 1'b0, 8'h55, 1'b1);
    waitIdle("single");
    checkOutput("single_locked", locked, 0);
    checkLine("single", 8'h55);

    // Round-robin from reset priority
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
    serveByte("rr0", 0, 8'hA0);
    serveByte("rr1", 1, 8'hA1);
    serveByte("rr2", 2, 8'hA2);
    serveByte("rr3", 3, 8'hA3);
    serveByte("rr4", 0, 8'hA0);
    req_valid = '0;
    waitIdle("rr");
    checkLine("rr0", 8'hA0);
    checkLine("rr1", 8'hA1);
    checkLine("rr2", 8'hA2);
    checkLine("rr3", 8'hA3);
    checkLine("rr4", 8'hA0);

    // Packet lock: req1 must wait for req0's three-byte packet
    applyReset();
    applyStimulus(0, 1'b1, 8'h11, 1'b0);
    applyStimulus(1, 1'b1, 8'h99, 1'b1);
    serveByte("pk0", 0, 8'h11);
    applyStimulus(0, 1'b1, 8'h22, 1'b0);
    waitIdle("pk0");
    checkOutput("pk0_locked", locked, 1);
    serveByte("pk1", 0, 8'h22);
    applyStimulus(0, 1'b1, 8'h33, 1'b1);
    waitIdle("pk1");
    checkOutput("pk1_locked", locked, 1);
    serveByte("pk2", 0, 8'h33);
    applyStimulus(0, 1'b0, 8'h33, 1'b1);
    waitIdle("pk2");
    checkOutput("pk2_locked", locked, 0);
    serveByte("pk3", 1, 8'h99);
    applyStimulus(1, 1'b0, 8'h99, 1'b1);
    waitIdle("pk3");
    checkLine("pk0", 8'h11);
    checkLine("pk1", 8'h22);
    checkLine("pk2", 8'h33);
    checkLine("pk3", 8'h99);

    // Lock holder stalls while req2 waits (grant_id=1, search 2,3,0 finds req0)
    applyStimulus(0, 1'b1, 8'h11, 1'b0);
    serveByte("st0", 0, 8'h11);
    applyStimulus(0, 1'b0, 8'h11, 1'b0);
    applyStimulus(2, 1'b1, 8'h77, 1'b1);
    waitIdle("st0");
    sc = start_count;
    repeat (100) @(negedge clk);
    checkOutput("st_nostart", start_count, sc);
    checkOutput("st_hold", {busy, locked, grant_id}, {1'b0, 1'b1, 2'd0});
    applyStimulus(0, 1'b1, 8'h12, 1'b1);
    serveByte("st1", 0, 8'h12);
    applyStimulus(0, 1'b0, 8'h12, 1'b1);
    waitIdle("st1");
    checkOutput("st1_locked", locked, 0);
    serveByte("st2", 2, 8'h77);
    applyStimulus(2, 1'b0, 8'h77, 1'b1);
    waitIdle("st2");
    checkLine("st0", 8'h11);
    checkLine("st1", 8'h12);
    checkLine("st2", 8'h77);

    // Timeout: take a lock, then the transmitter ignores the next start
    applyStimulus(0, 1'b1, 8'h21, 1'b0);
    serveByte("to0", 0, 8'h21);
    tie_high = 1'b1;
    applyStimulus(0, 1'b1, 8'h22, 1'b0);
    waitIdle("to0");
    checkOutput("to0_locked", locked, 1);
    serveByte("to1", 0, 8'h22);
    applyStimulus(0, 1'b0, 8'h22, 1'b0);
    repeat (DONE_TIMEOUT - 1) @(negedge clk);
    checkOutput("to_before", {err_timeout, locked}, 2'b01);
    @(negedge clk);
    checkOutput("to_pulse", {err_timeout, locked, busy}, 3'b100);
    @(negedge clk);
    checkOutput("to_after", err_timeout, 0);
    tie_high = 1'b0;
    applyStimulus(1, 1'b1, 8'h3C, 1'b1);
    serveByte("to2", 1, 8'h3C);
    applyStimulus(1, 1'b0, 8'h3C, 1'b1);
    waitIdle("to2");
    checkLine("to0", 8'h21);
    checkLine("to2", 8'h3C);

    // Reset in WAIT_HIGH, then default priority serves req3
    applyStimulus(2, 1'b1, 8'h44, 1'b1);
    serveByte("rm0", 2, 8'h44);
    applyStimulus(2, 1'b0, 8'h44, 1'b1);
    for (int k = 0; k < BUDGET && uart_tx_done; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("rm_busy", {busy, uart_tx_done}, 2'b10);
    rst = 1'b1;
    #1;
    checkOutput("rm_ready", req_ready, 0);
    checkOutput("rm_out", {uart_tx_start, uart_tx_data, grant_id}, {1'b0, 8'h00, 2'd3});
    checkOutput("rm_flags", {busy, locked, err_timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(3, 1'b1, 8'h66, 1'b1);
    serveByte("rm1", 3, 8'h66);
    applyStimulus(3, 1'b0, 8'h66, 1'b1);
    waitIdle("rm1");
    checkLine("rm0", 8'h44);
    checkLine("rm1", 8'h66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
